// File: rtl/candy_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : candy_div_ctrl
// Description : Multi-cycle restoring radix-2 divider with its sequencing FSM
//               for the execute stage. Returns {remainder, quotient} and holds
//               the pipeline through stallreq_o while a divide is in flight.
//               Optional feature macro: CANDY_DIV_SKIP_EN (early completion
//               when |dividend| < |divisor|).
// Revision    : 1.0 - initial release
// ============================================================================
module candy_div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]   rem_q, rem_d;     // partial remainder
  logic [DATA_W-1:0]   dsr_q, dsr_d;     // divisor magnitude
  logic                sdiv_q, sdiv_d;   // signed operation
  logic                neg1_q, neg1_d;   // dividend was negative
  logic                neg2_q, neg2_d;   // divisor was negative
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                w_neg1, w_neg2, w_skip, w_ge;
  logic [DATA_W-1:0]   w_abs1, w_abs2, w_rem_next, w_quo_next, w_quo_fix, w_rem_fix;
  logic [DATA_W:0]     w_rem_shift, w_diff;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // the correct unsigned magnitude.
  assign w_neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign w_neg2 = signed_div_i & opdata2_i[DATA_W-1];
  assign w_abs1 = w_neg1 ? -opdata1_i : opdata1_i;
  assign w_abs2 = w_neg2 ? -opdata2_i : opdata2_i;

`ifdef CANDY_DIV_SKIP_EN
  assign w_skip = (w_abs1 < w_abs2);
`else
  assign w_skip = 1'b0;
`endif

  // One restoring step: the remainder stays below the divisor, so the
  // difference always fits in DATA_W+1 bits and its top bit is the borrow.
  assign w_rem_shift = {rem_q, dvd_q[DATA_W-1]};
  assign w_diff      = w_rem_shift - {1'b0, dsr_q};
  assign w_ge        = ~w_diff[DATA_W];
  assign w_rem_next  = w_ge ? w_diff[DATA_W-1:0] : w_rem_shift[DATA_W-1:0];
  assign w_quo_next  = {dvd_q[DATA_W-2:0], w_ge};

  // Sign correction: quotient sign is the XOR of operand signs, remainder
  // follows the dividend.
  assign w_quo_fix = (sdiv_q & (neg1_q ^ neg2_q)) ? -w_quo_next : w_quo_next;
  assign w_rem_fix = (sdiv_q & neg1_q) ? -w_rem_next : w_rem_next;

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = (state_q != S_FREE);
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      sdiv_q   <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      sdiv_q   <= sdiv_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    sdiv_d   = sdiv_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          sdiv_d = signed_div_i;
          neg1_d = w_neg1;
          neg2_d = w_neg2;
          cnt_d  = '0;
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
            dvd_d   = '0;
            rem_d   = '0;
            dsr_d   = '0;
          end else if (w_skip) begin
            // Quotient is zero and the remainder is the raw dividend.
            state_d = S_END;
            dvd_d   = '0;
            rem_d   = opdata1_i;
            dsr_d   = w_abs2;
          end else begin
            state_d = S_ON;
            dvd_d   = w_abs1;
            rem_d   = '0;
            dsr_d   = w_abs2;
          end
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
        end else begin
          state_d = S_END;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
        end else begin
          dvd_d = w_quo_next;
          rem_d = w_rem_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_ITER) begin
            result_d = {w_rem_fix, w_quo_fix};
            ready_d  = 1'b1;
            state_d  = S_END;
          end
        end
      end

      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (!ready_q) begin
          // Divide-by-zero and early-completion paths publish here.
          ready_d  = 1'b1;
          result_d = {rem_q, dvd_q};
        end
      end

      default: begin
        state_d = S_FREE;
      end
    endcase
  end

endmodule
`default_nettype wire
